// File: rtl/cpu_pkg.sv
// Shared constants for the mini CPU datapath.
// Data/address/opcode widths and ALU opcode encodings.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_SHR = 3'b111;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 3-bit-opcode ALU, no flags.
// Shifts use only the low four bits of operand B.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int W  = DATA_W,
    parameter int OW = OP_W
) (
    input  logic [W-1:0]  register_A,
    input  logic [W-1:0]  register_B,
    input  logic [OW-1:0] opcode,
    output logic [W-1:0]  result
);

    logic [3:0] shamt;

    assign shamt = register_B[3:0];

    // Select the operation; arithmetic wraps modulo 2**W
    always_comb begin
        result = '0;
        unique case (opcode)
            OP_ADD: result = register_A + register_B;
            OP_SUB: result = register_A - register_B;
            OP_AND: result = register_A & register_B;
            OP_OR:  result = register_A | register_B;
            OP_XOR: result = register_A ^ register_B;
            OP_NOT: result = ~register_A;
            OP_SHL: result = register_A << shamt;
            OP_SHR: result = register_A >> shamt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Register file (16 x 16) with two combinational read ports
// and one synchronous write port, feeding the ALU directly.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W,
    parameter int OW = OP_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] read_reg1,
    input  logic [AW-1:0] read_reg2,
    input  logic [AW-1:0] write_reg,
    input  logic [DW-1:0] write_data,
    input  logic          reg_write_en,
    input  logic [OW-1:0] alu_opcode,
    output logic [DW-1:0] read_data1,
    output logic [DW-1:0] read_data2,
    output logic [DW-1:0] alu_result
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] regs [NREG];

    // Register array: async clear, one write per rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write_en) begin
            regs[write_reg] <= write_data;
        end
    end

    // No bypass: reads see the stored value until the write edge
    assign read_data1 = regs[read_reg1];
    assign read_data2 = regs[read_reg2];

    cpu_alu #(
        .W  (DW),
        .OW (OW)
    ) u_alu (
        .register_A (read_data1),
        .register_B (read_data2),
        .opcode     (alu_opcode),
        .result     (alu_result)
    );

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: directed vectors push
// expected values, a monitor process pops and compares.
module tb_cpu_datapath;

    logic        clk;
    logic        rst_n;
    logic [3:0]  read_reg1;
    logic [3:0]  read_reg2;
    logic [3:0]  write_reg;
    logic [15:0] write_data;
    logic        reg_write_en;
    logic [2:0]  alu_opcode;
    logic [15:0] read_data1;
    logic [15:0] read_data2;
    logic [15:0] alu_result;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    cpu_datapath dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .reg_write_en (reg_write_en),
        .alu_opcode   (alu_opcode),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .alu_result   (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops each expectation as soon as it is queued
    initial begin
        exp_t        e;
        logic [15:0] act;
        vectors     = 0;
        miscompares = 0;
        forever begin
            wait (sb.size() != 0);
            e = sb.pop_front();
            case (e.sel)
                0:       act = read_data1;
                1:       act = read_data2;
                default: act = alu_result;
            endcase
            vectors++;
            if (act !== e.val) begin
                miscompares++;
                $display("FAIL %s: got 0x%04h, expected 0x%04h",
                         e.name, act, e.val);
            end
        end
    end

    task automatic expect_out(input string n, input int sel,
                              input logic [15:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.val  = v;
        sb.push_back(e);
        #0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d,
                      input logic en);
        @(negedge clk);
        write_reg    = a;
        write_data   = d;
        reg_write_en = en;
        @(posedge clk);
        #1;
        reg_write_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2,
                      input logic [2:0] op);
        @(negedge clk);
        read_reg1  = a1;
        read_reg2  = a2;
        alu_opcode = op;
        #1;
    endtask

    logic [2:0]  ops  [6];
    logic [15:0] exps [6];
    string       nms  [6];

    initial begin
        ops  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        exps = '{16'h100E, 16'hF1F0, 16'h000F,
                 16'h0FFF, 16'h0FF0, 16'hFF00};
        nms  = '{"alu_add", "alu_sub", "alu_and",
                 "alu_or", "alu_xor", "alu_not"};

        rst_n        = 1'b0;
        read_reg1    = '0;
        read_reg2    = '0;
        write_reg    = '0;
        write_data   = '0;
        reg_write_en = 1'b0;
        alu_opcode   = 3'd0;
        #2;
        expect_out("reset_rd1", 0, 16'h0000);
        expect_out("reset_add", 2, 16'h0000);
        alu_opcode = 3'd5;
        #1;
        expect_out("reset_not", 2, 16'hFFFF);

        // release reset with a write pending: reset high at edge
        @(negedge clk);
        rst_n        = 1'b1;
        write_reg    = 4'd8;
        write_data   = 16'h7777;
        reg_write_en = 1'b1;
        @(posedge clk);
        #1;
        reg_write_en = 1'b0;
        rd(4'd8, 4'd0, 3'd0);
        expect_out("release_write", 0, 16'h7777);

        wr(4'd5, 16'h00FF, 1'b1);
        wr(4'd6, 16'h0F0F, 1'b1);
        rd(4'd5, 4'd6, 3'd0);
        expect_out("rd1_r5", 0, 16'h00FF);
        expect_out("rd2_r6", 1, 16'h0F0F);
        wr(4'd5, 16'hAAAA, 1'b0);
        rd(4'd5, 4'd6, 3'd0);
        expect_out("en0_keeps", 0, 16'h00FF);

        for (int i = 0; i < 6; i++) begin
            rd(4'd5, 4'd6, ops[i]);
            expect_out(nms[i], 2, exps[i]);
        end

        wr(4'd2, 16'h8001, 1'b1);
        wr(4'd9, 16'h0011, 1'b1);
        rd(4'd2, 4'd9, 3'd6);
        expect_out("shl", 2, 16'h0002);
        rd(4'd2, 4'd9, 3'd7);
        expect_out("shr", 2, 16'h4000);

        wr(4'd1, 16'hFFFF, 1'b1);
        rd(4'd1, 4'd1, 3'd0);
        expect_out("same_rd2", 1, 16'hFFFF);
        expect_out("wrap_add", 2, 16'hFFFE);
        rd(4'd1, 4'd1, 3'd1);
        expect_out("same_sub", 2, 16'h0000);

        wr(4'd0, 16'hBEEF, 1'b1);
        rd(4'd0, 4'd1, 3'd0);
        expect_out("r0_general", 0, 16'hBEEF);

        // no bypass: old value before the edge, new after
        @(negedge clk);
        read_reg1    = 4'd7;
        write_reg    = 4'd7;
        write_data   = 16'h5555;
        reg_write_en = 1'b1;
        #1;
        expect_out("nobypass_old", 0, 16'h0000);
        @(posedge clk);
        #1;
        reg_write_en = 1'b0;
        expect_out("nobypass_new", 0, 16'h5555);

        // async reset mid-cycle, no clock edge in between
        wr(4'd3, 16'h1234, 1'b1);
        rd(4'd3, 4'd0, 3'd0);
        expect_out("r3_written", 0, 16'h1234);
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("async_clear", 0, 16'h0000);

        // write attempted under reset is dropped
        write_reg    = 4'd4;
        write_data   = 16'h4444;
        reg_write_en = 1'b1;
        @(posedge clk);
        #1;
        reg_write_en = 1'b0;
        rd(4'd4, 4'd0, 3'd0);
        expect_out("reset_blocks_wr", 0, 16'h0000);

        for (int t = 0; t < 100 && sb.size() != 0; t++) #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
